// File: rtl/nc_coef_pkg.sv
// Shared types and constants for the noise-cancelling coefficient sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nc_coef_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_TICK = 3'd2,
        SWAP      = 3'd3,
        ERR       = 3'd4
    } state_t;

    // Control bit positions inside J_PORT
    localparam int unsigned GO_BIT    = 0;
    localparam int unsigned CLR_BIT   = 1;

    // Size of the snapshot bank (A_PORT..I_PORT)
    localparam int unsigned MAX_WORDS = 9;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned WD_W      = 16;
    localparam int unsigned CNT_W     = 16;

endpackage

// File: rtl/nc_hs_watchdog.sv
// Handshake watchdog: counts stalled cycles and flags expiry at TIMEOUT.
// Latency: expired_o is combinational in the cycle the count equals TIMEOUT.
// Backpressure: none; clear_i has priority over counting.
module nc_hs_watchdog
    import nc_coef_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic cnt_en_i,
    output logic expired_o
);

    logic [WD_W-1:0] cnt_q;
    logic [WD_W-1:0] cnt_d;

    // Expiry only counts in a stalled cycle, so a transfer on the limit cycle wins
    assign expired_o = cnt_en_i && (cnt_q == WD_W'(TIMEOUT));

    // Next count: clear, else advance while stalled; hold once expired
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_en_i && !expired_o) begin
            cnt_d = cnt_q + WD_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nc_coef_sequencer.sv
// Uploads a snapshot of A..I_PORT into the filter shadow bank, then swaps banks on a sample tick.
// Latency: GO register change -> COEF_VALID two cycles later; tick -> BANK_SWAP next cycle.
// Backpressure: COEF_VALID/COEF_READY; words hold while READY is low, watchdog aborts after TIMEOUT.
module nc_coef_sequencer
    import nc_coef_pkg::*;
#(
    parameter int NUM_WORDS = 9,
    parameter int ADDR_W    = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESETN,
    input  logic [DATA_W-1:0]   A_PORT,
    input  logic [DATA_W-1:0]   B_PORT,
    input  logic [DATA_W-1:0]   C_PORT,
    input  logic [DATA_W-1:0]   D_PORT,
    input  logic [DATA_W-1:0]   E_PORT,
    input  logic [DATA_W-1:0]   F_PORT,
    input  logic [DATA_W-1:0]   G_PORT,
    input  logic [DATA_W-1:0]   H_PORT,
    input  logic [DATA_W-1:0]   I_PORT,
    input  logic [DATA_W-1:0]   J_PORT,
    input  logic                SAMPLE_TICK,
    output logic [ADDR_W-1:0]   COEF_ADDR,
    output logic [DATA_W-1:0]   COEF_DATA,
    output logic                COEF_VALID,
    input  logic                COEF_READY,
    output logic                BANK_SWAP,
    output logic                BUSY,
    output logic                ERROR,
    output logic [CNT_W-1:0]    LOAD_COUNT
);

    state_t              state_q, state_d;
    logic [1:0]          j_q, j_prev_q;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]    load_cnt_q, load_cnt_d;
    logic [DATA_W-1:0]   snap_q [MAX_WORDS];
    logic [DATA_W-1:0]   word_sel;
    logic                go_edge, clr_edge;
    logic                snap_en, xfer, last_word;
    logic                wd_clear, wd_en, wd_expired;
    logic                unused_j;

    // Only GO and CLR_ERR carry meaning; remaining control bits are don't-care
    assign unused_j  = ^J_PORT[DATA_W-1:2];

    // Edges are taken from the registered copy so GO timing is independent of write skew
    assign go_edge   = j_q[0] & ~j_prev_q[0];
    assign clr_edge  = j_q[1] & ~j_prev_q[1];

    assign snap_en   = (state_q == IDLE) && go_edge;
    assign xfer      = (state_q == LOAD) && COEF_READY;
    assign last_word = (idx_q == ADDR_W'(NUM_WORDS - 1));

    // Watchdog restarts on entry to LOAD (cleared while outside) and on every accepted word
    assign wd_clear  = (state_q != LOAD) || xfer;
    assign wd_en     = (state_q == LOAD) && !COEF_READY;

    nc_hs_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (S_AXI_ACLK),
        .rst_ni    (S_AXI_ARESETN),
        .clear_i   (wd_clear),
        .cnt_en_i  (wd_en),
        .expired_o (wd_expired)
    );

    // Control-bit history for edge detection
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            j_q      <= '0;
            j_prev_q <= '0;
        end else begin
            j_q      <= {J_PORT[CLR_BIT], J_PORT[GO_BIT]};
            j_prev_q <= j_q;
        end
    end

    // State register
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; GO outside IDLE and ticks outside WAIT_TICK fall through unused
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (go_edge) state_d = LOAD;
            LOAD: begin
                if (xfer && last_word) begin
                    state_d = WAIT_TICK;
                end else if (wd_expired) begin
                    state_d = ERR;
                end
            end
            WAIT_TICK: if (SAMPLE_TICK) state_d = SWAP;
            SWAP:      state_d = IDLE;
            ERR:       if (clr_edge) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Word index and commit counter next-state
    always_comb begin
        idx_d      = idx_q;
        load_cnt_d = load_cnt_q;
        if (snap_en) begin
            idx_d = '0;
        end else if (xfer && !last_word) begin
            idx_d = idx_q + ADDR_W'(1);
        end
        if (state_q == SWAP) begin
            load_cnt_d = load_cnt_q + CNT_W'(1);
        end
    end

    // Index and commit counter registers
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            idx_q      <= '0;
            load_cnt_q <= '0;
        end else begin
            idx_q      <= idx_d;
            load_cnt_q <= load_cnt_d;
        end
    end

    // Snapshot bank: frozen at GO so later register writes cannot tear the set in flight
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int k = 0; k < MAX_WORDS; k++) begin
                snap_q[k] <= '0;
            end
        end else if (snap_en) begin
            snap_q[0] <= A_PORT;
            snap_q[1] <= B_PORT;
            snap_q[2] <= C_PORT;
            snap_q[3] <= D_PORT;
            snap_q[4] <= E_PORT;
            snap_q[5] <= F_PORT;
            snap_q[6] <= G_PORT;
            snap_q[7] <= H_PORT;
            snap_q[8] <= I_PORT;
        end
    end

    // Select the snapshot word addressed by the current index
    always_comb begin
        word_sel = '0;
        for (int k = 0; k < MAX_WORDS; k++) begin
            if (idx_q == ADDR_W'(k)) begin
                word_sel = snap_q[k];
            end
        end
    end

    // Outputs decoded from state only, so reset clears them immediately
    always_comb begin
        COEF_VALID = 1'b0;
        COEF_ADDR  = '0;
        COEF_DATA  = '0;
        BANK_SWAP  = 1'b0;
        BUSY       = 1'b0;
        ERROR      = 1'b0;
        LOAD_COUNT = load_cnt_q;
        unique case (state_q)
            LOAD: begin
                COEF_VALID = 1'b1;
                COEF_ADDR  = idx_q;
                COEF_DATA  = word_sel;
                BUSY       = 1'b1;
            end
            WAIT_TICK: BUSY = 1'b1;
            SWAP: begin
                BUSY      = 1'b1;
                BANK_SWAP = 1'b1;
            end
            ERR:     ERROR = 1'b1;
            default: ;
        endcase
    end

endmodule
